div_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the EX-stage integer divide, owning the iterative restoring-division datapath (one quotient bit per cycle).
- Accepts DIV/DIVU from EX, holds the pipeline through stall_req, and handles div-by-zero and signed overflow as single-cycle fast paths.
- Applies sign correction and returns a double-width {remainder, quotient} result with a one-cycle done pulse.
- Honours pipeline flush at any point.

---
 rtl/div_seq_ctrl.sv | 110 +++++++++++
 tb/tb_div_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for the EX stage: one quotient bit per cycle,
// single-cycle fast paths for divide-by-zero and signed overflow.
module div_seq_ctrl #(
    parameter int                 WIDTH      = 32,
    parameter int                 CNT_W      = 6,
    parameter int                 FUNCT_W    = 6,
    parameter logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010,
    parameter logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 div_en,
    input  logic [WIDTH-1:0]     operand_1,
    input  logic [WIDTH-1:0]     operand_2,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_div
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic               is_sgn, s1, s2;
    logic [WIDTH-1:0]   dvsr, q;
    logic [WIDTH:0]     r;
    logic [CNT_W-1:0]   cnt;

    logic               funct_ok, sgn_in, in_s1, in_s2, accept, div_zero, ovf;
    logic [WIDTH-1:0]   mag1, mag2, quo_fix, rem_fix;
    logic [WIDTH:0]     shifted, diff;

    always_comb begin
        funct_ok = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
        sgn_in   = (funct == FUNCT_DIV);
        in_s1    = sgn_in & operand_1[WIDTH-1];
        in_s2    = sgn_in & operand_2[WIDTH-1];
        mag1     = in_s1 ? -operand_1 : operand_1;
        mag2     = in_s2 ? -operand_2 : operand_2;
        accept   = (state == IDLE) && div_en && funct_ok && !flush;
        div_zero = (operand_2 == '0);
        ovf      = sgn_in && (operand_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_2 == '1);
        shifted  = {r[WIDTH-1:0], q[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr};
        // remainder follows the dividend's sign; quotient sign is s1 ^ s2
        quo_fix  = (is_sgn && (s1 ^ s2)) ? -q : q;
        rem_fix  = (is_sgn && s1) ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush && state != IDLE) state_nxt = IDLE;
    end

    always_comb begin
        busy      = (state == CALC) || (state == FIX);
        done      = (state == DONE) && !flush;
        stall_req = accept || (busy && !flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_sgn     <= 1'b0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            dvsr       <= '0;
            q          <= '0;
            r          <= '0;
            cnt        <= '0;
            result_div <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_sgn <= sgn_in;
                s1     <= operand_1[WIDTH-1];
                s2     <= operand_2[WIDTH-1];
                dvsr   <= mag2;
                q      <= mag1;
                r      <= '0;
                cnt    <= '0;
                if (div_zero)
                    result_div <= {operand_1, {WIDTH{1'b1}}};
                else if (ovf)
                    result_div <= {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
            end else if (state == CALC && !flush) begin
                if (!diff[WIDTH]) begin
                    r <= diff;
                    q <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    r <= shifted;
                    q <= {q[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end else if (state == FIX && !flush) begin
                result_div <= {rem_fix, quo_fix};
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed divides push expected results,
// a monitor pops and compares on every done pulse.
module tb_div_seq_ctrl;

    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  funct;
    logic        div_en, flush;
    logic [31:0] operand_1, operand_2;
    logic        stall_req, busy, done;
    logic [63:0] result_div;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   passed = 0, total = 0;

    div_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .funct(funct), .div_en(div_en),
        .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .result_div(result_div)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: every done pulse must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_div", result_div, e.res);
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("done_missing", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives a request at the start of the current cycle; returns at start of N+1
    task automatic accept_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              output int n);
        funct = f; operand_1 = a; operand_2 = b; div_en = 1'b1;
        @(negedge clk);
        check("stall_at_accept", 64'(stall_req), 64'd1);
        n = cyc;
        tick();
        div_en = 1'b0;
    endtask

    task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int lat);
        int   n;
        exp_t e;
        accept_req(f, a, b, n);
        e.res = exp_res;
        e.cyc = n + lat;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (stall_req !== (k < lat)) check("stall_window", 64'(stall_req), 64'(k < lat));
            else if (k == lat) check("stall_window", 64'(stall_req), 64'd0);
        end
    endtask

    initial begin
        int          n;
        logic [63:0] prev;
        rst_n = 1'b0; funct = '0; div_en = 1'b0; flush = 1'b0;
        operand_1 = '0; operand_2 = '0;
        tick(); tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result_div, 64'd0);
        rst_n = 1'b1;
        tick();

        // unsupported funct is ignored
        funct = 6'h00; div_en = 1'b1; operand_1 = 32'd9; operand_2 = 32'd3;
        @(negedge clk);
        check("bad_funct_stall", 64'(stall_req), 64'd0);
        tick();
        div_en = 1'b0;
        check("bad_funct_busy", 64'(busy), 64'd0);

        tick(); run(F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        tick(); run(F_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        tick(); run(F_DIV, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
        tick(); run(F_DIVU, 32'h5, 32'h0, {32'h5, 32'hFFFF_FFFF}, 1);
        tick(); run(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1);
        tick(); run(F_DIV, 32'hFFFF_FFF9, 32'h0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1);
        tick(); run(F_DIVU, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 34);
        tick(); run(F_DIVU, 32'd3, 32'd10, {32'd3, 32'd0}, 34);

        // flush mid-calc at N+10, then a new divide at N+11
        tick();
        prev = result_div;
        accept_req(F_DIVU, 32'd100, 32'd7, n);
        repeat (9) tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_req), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_result_kept", result_div, prev);
        check("flush_cycle", 64'(cyc), 64'(n + 11));
        run(F_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

        // async reset mid-calc at N+20
        tick();
        accept_req(F_DIVU, 32'd100, 32'd7, n);
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_stall", 64'(stall_req), 64'd0);
        check("rst_mid_result", result_div, 64'd0);
        tick();
        rst_n = 1'b1;
        tick(); run(F_DIVU, 32'd20, 32'd6, {32'd2, 32'd3}, 34);

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
